load_grant_scheduler: RTL and testbench

Round-robin grant scheduler that shares the single external ICB read port among the tile loaders: bias loader, IA loader and weight loader. Each loader raises a load request and waits for a one-cycle grant. It then owns the bus until it pulses done. A watchdog forcibly reclaims the bus from an owner that never finishes. The block sits between the loaders' req/granted handshakes and the ICB port mux, and drives the mux select.

---
 rtl/load_grant_scheduler.sv | 163 ++++++++++++++++
 tb/tb_load_grant_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_grant_scheduler.sv
// Round-robin owner arbitration of the shared ICB read port among the tile loaders.
// Latency: req seen in IDLE -> one-cycle granted pulse next cycle; release -> next grant >= 2 cycles later.
// Backpressure: requests are not queued; req is a level held until granted, and is ignored while the bus is owned.
module load_grant_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int WD_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_cfg,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] granted,
  input  logic [NUM_REQ-1:0] done,
  output logic               bus_busy,
  output logic [IDX_W-1:0]   bus_sel,
  output logic               timeout_err,
  output logic [IDX_W-1:0]   timeout_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Last legal watchdog count; unused when the watchdog is disabled.
  localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam bit               WD_EN    = (TIMEOUT_CYC != 0);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   granted_q, granted_d;
  logic                 bus_busy_q, bus_busy_d;
  logic [IDX_W-1:0]     bus_sel_q, bus_sel_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]     timeout_id_q, timeout_id_d;

  logic [IDX_W-1:0]     rr_win;
  logic [IDX_W-1:0]     scan_idx;
  logic                 rr_found;
  logic [IDX_W-1:0]     sel_next;
  logic                 owner_done;
  logic                 wd_hit;

  // Round-robin winner: first set req bit scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!rr_found && req[scan_idx]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx;
      end
    end
  end

  // Pointer successor of the current owner, the owner's done bit and watchdog expiry.
  always_comb begin
    sel_next   = (bus_sel_q == IDX_LAST) ? '0 : bus_sel_q + IDX_W'(1);
    owner_done = done[bus_sel_q];
    wd_hit     = WD_EN && (wd_cnt_q == WD_LAST);
  end

  // Next-state and registered-output logic for the IDLE/GRANT/BUSY ownership FSM.
  always_comb begin
    state_d       = state_q;
    granted_d     = '0;
    bus_busy_d    = bus_busy_q;
    bus_sel_d     = bus_sel_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    timeout_id_d  = timeout_id_q;

    // Clear error status first so a watchdog firing in the same cycle is not lost.
    if (init_cfg) begin
      timeout_err_d = 1'b0;
      timeout_id_d  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        bus_busy_d = 1'b0;
        if (rr_found) begin
          bus_sel_d  = rr_win;
          granted_d  = NUM_REQ'(1) << rr_win;
          bus_busy_d = 1'b1;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_cnt_d = '0;
        rr_ptr_d = sel_next;
        if (owner_done) begin
          bus_busy_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          bus_busy_d = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Owner completion takes priority over a simultaneous watchdog expiry.
        if (owner_done) begin
          bus_busy_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (wd_hit) begin
          bus_busy_d    = 1'b0;
          timeout_err_d = 1'b1;
          timeout_id_d  = bus_sel_q;
          state_d       = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: begin
        bus_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Reconfiguration restarts the rotation even if a grant is updating the pointer.
    if (init_cfg) begin
      rr_ptr_d = '0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      granted_q     <= '0;
      bus_busy_q    <= 1'b0;
      bus_sel_q     <= '0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      state_q       <= state_d;
      granted_q     <= granted_d;
      bus_busy_q    <= bus_busy_d;
      bus_sel_q     <= bus_sel_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign granted     = granted_q;
  assign bus_busy    = bus_busy_q;
  assign bus_sel     = bus_sel_q;
  assign timeout_err = timeout_err_q;
  assign timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_load_grant_scheduler.sv
// Directed bench for load_grant_scheduler with a 16-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived per scenario.
module tb_load_grant_scheduler;

  logic       clk;
  logic       rst_n;
  logic       init_cfg;
  logic [2:0] req;
  logic [2:0] granted;
  logic [2:0] done;
  logic       bus_busy;
  logic [1:0] bus_sel;
  logic       timeout_err;
  logic [1:0] timeout_id;

  int total;
  int bad;

  load_grant_scheduler #(
    .NUM_REQ    (3),
    .TIMEOUT_CYC(16),
    .WD_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_cfg   (init_cfg),
    .req        (req),
    .granted    (granted),
    .done       (done),
    .bus_busy   (bus_busy),
    .bus_sel    (bus_sel),
    .timeout_err(timeout_err),
    .timeout_id (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] one;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    init_cfg = 1'b0;
    req      = '0;
    done     = '0;

    // Reset state
    #12;
    chk("rst_granted", 32'(granted), 0);
    chk("rst_busy", 32'(bus_busy), 0);
    chk("rst_sel", 32'(bus_sel), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_id", 32'(timeout_id), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single requester: one-cycle grant, busy until done, release next cycle
    req = 3'b001;
    tick();
    chk("t1_grant", 32'(granted), 32'h1);
    chk("t1_busy_g", 32'(bus_busy), 1);
    chk("t1_sel", 32'(bus_sel), 0);
    req = '0;
    tick();
    chk("t1_grant_pulse", 32'(granted), 0);
    chk("t1_busy_b", 32'(bus_busy), 1);
    repeat (3) tick();
    chk("t1_busy_last", 32'(bus_busy), 1);
    done = 3'b001;
    tick();
    done = '0;
    chk("t1_release", 32'(bus_busy), 0);
    chk("t1_sel_held", 32'(bus_sel), 0);

    // Fairness: all requesting from rr_ptr=0, strict rotation 0,1,2 then wrap to 0
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      one = 3'(1 << k);
      tick();
      chk("t2_grant", 32'(granted), 32'(one));
      chk("t2_sel", 32'(bus_sel), 32'(k));
      req = req & ~one;
      repeat (3) tick();
      chk("t2_busy", 32'(bus_busy), 1);
      done = one;
      tick();
      done = '0;
      chk("t2_release", 32'(bus_busy), 0);
    end
    req = 3'b111;
    tick();
    chk("t2_wrap_grant", 32'(granted), 32'h1);
    req = '0;
    tick();
    done = 3'b001;
    tick();
    done = '0;

    // Non-owner done pulses are ignored
    req = 3'b010;
    tick();
    chk("t3_grant", 32'(granted), 32'h2);
    req = '0;
    tick();
    done = 3'b101;
    tick();
    done = '0;
    chk("t3_busy_ign", 32'(bus_busy), 1);
    chk("t3_sel_ign", 32'(bus_sel), 1);
    tick();
    chk("t3_busy_ign2", 32'(bus_busy), 1);
    done = 3'b010;
    tick();
    done = '0;
    chk("t3_release", 32'(bus_busy), 0);
    chk("t3_sel_held", 32'(bus_sel), 1);

    // Watchdog: owner 2 never finishes, bus reclaimed after 16 BUSY cycles
    req = 3'b100;
    tick();
    chk("t4_grant", 32'(granted), 32'h4);
    req = '0;
    repeat (16) tick();
    chk("t4_busy16", 32'(bus_busy), 1);
    chk("t4_err_before", 32'(timeout_err), 0);
    tick();
    chk("t4_reclaim", 32'(bus_busy), 0);
    chk("t4_err", 32'(timeout_err), 1);
    chk("t4_id", 32'(timeout_id), 2);
    init_cfg = 1'b1;
    tick();
    init_cfg = 1'b0;
    chk("t4_err_clr", 32'(timeout_err), 0);
    chk("t4_id_clr", 32'(timeout_id), 0);
    req = 3'b100;
    tick();
    chk("t4_grant2", 32'(granted), 32'h4);
    req = '0;
    repeat (16) tick();
    done = 3'b100;
    tick();
    done = '0;
    chk("t4_done_release", 32'(bus_busy), 0);
    chk("t4_done_no_err", 32'(timeout_err), 0);

    // Early done in the GRANT cycle, pending request granted 2 cycles after done
    req = 3'b011;
    tick();
    chk("t5_grant", 32'(granted), 32'h1);
    done = 3'b001;
    req  = 3'b010;
    tick();
    done = '0;
    chk("t5_idle_busy", 32'(bus_busy), 0);
    chk("t5_idle_gnt", 32'(granted), 0);
    tick();
    chk("t5_next_grant", 32'(granted), 32'h2);
    chk("t5_next_sel", 32'(bus_sel), 1);
    req = '0;
    tick();
    done = 3'b010;
    tick();
    done = '0;

    // Reset mid-BUSY clears outputs asynchronously and restarts the rotation at 0
    req = 3'b010;
    tick();
    chk("t6_grant", 32'(granted), 32'h2);
    req = '0;
    tick();
    chk("t6_busy", 32'(bus_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_busy", 32'(bus_busy), 0);
    chk("t6_arst_sel", 32'(bus_sel), 0);
    chk("t6_arst_gnt", 32'(granted), 0);
    #1;
    rst_n = 1'b1;
    req = 3'b110;
    tick();
    chk("t6_post_grant", 32'(granted), 32'h2);
    chk("t6_post_sel", 32'(bus_sel), 1);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
